dht11_driver: RTL and testbench

- Single-wire physical driver for the DHT11 temperature/humidity sensor. It sits directly upstream of the sensor connection/command block.
- On request it performs one full DHT11 read transaction on the open-drain `transmission_line`.
- It delivers the raw 40-bit frame plus a data-valid flag (`dadosOK`) and an error flag (`error`).
- Checksum validation is not done here; the consumer does it.

---
 rtl/dht11_driver_if.sv | 14 +
 rtl/dht11_driver.sv | 189 ++++++++++++++++++
 tb/tb_dht11_driver.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_driver_if.sv
// dht11_driver_if: request/result bundle between the DHT11 line driver and its consumer.
//   enable      - level request from the consumer; a read starts while high
//   sensor_data - last good 40-bit frame {hum int, hum dec, temp int, temp dec, checksum}
//   error       - last transaction timed out
//   dadosOK     - transaction finished successfully
interface dht11_driver_if;
   logic        enable;
   logic [39:0] sensor_data;
   logic        error;
   logic        dadosOK;

   modport master (output enable, input sensor_data, error, dadosOK);
   modport slave  (input enable, output sensor_data, error, dadosOK);
endinterface

// File: rtl/dht11_driver.sv
// dht11_driver: single-wire physical driver for the DHT11 sensor. Issues the host start
// pulse on the open-drain line, decodes the 40-bit reply by high-phase length and reports
// the raw frame plus success/timeout flags. Checksum validation is left to the consumer.
// Ports:
//   clock             - system clock
//   reset_n           - asynchronous reset, active-low
//   transmission_line - open-drain DHT11 data line (driven 0 or released, external pull-up)
//   bus               - dht11_driver_if slave: enable in; sensor_data, error, dadosOK out
module dht11_driver #(
   parameter int unsigned CLK_CYCLES_PER_US = 50,
   parameter int unsigned START_LOW_US      = 19000,
   parameter int unsigned TIMEOUT_US        = 100,
   parameter int unsigned BIT_THRESHOLD_US  = 48,
   parameter int unsigned MIN_INTERVAL_US   = 1000000
) (
   input  logic          clock,
   input  logic          reset_n,
   inout  wire           transmission_line,
   dht11_driver_if.slave bus
);

   localparam int unsigned PW = (CLK_CYCLES_PER_US > 1) ? $clog2(CLK_CYCLES_PER_US) : 1;
   localparam logic [19:0] StartCnt   = 20'(START_LOW_US);
   localparam logic [19:0] TimeoutCnt = 20'(TIMEOUT_US);
   localparam logic [19:0] ThreshCnt  = 20'(BIT_THRESHOLD_US);
   localparam logic [19:0] MinCnt     = 20'(MIN_INTERVAL_US);

   typedef enum logic [3:0] {
      StIdle, StStartLow, StWaitResp, StRespLow, StRespHigh,
      StBitLow, StBitHigh, StDone, StFail, StHold
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [19:0]   us_cnt_q, us_cnt_d;
   logic [19:0]   guard_q, guard_d;
   logic [5:0]    bit_idx_q, bit_idx_d;
   logic [39:0]   shift_q, shift_d;
   logic [39:0]   data_q, data_d;
   logic          drive_low_q, drive_low_d;
   logic          error_q, error_d;
   logic          ok_q, ok_d;
   logic          meta_q, sync_q, prev_q;
   logic          tick, fall, rise, start, timeout;

   assign transmission_line = drive_low_q ? 1'b0 : 1'bz;

   assign tick    = (presc_q == PW'(CLK_CYCLES_PER_US - 1));
   assign fall    = prev_q & ~sync_q;
   assign rise    = ~prev_q & sync_q;
   assign start   = (state_q == StIdle) && bus.enable && (guard_q == MinCnt);
   assign timeout = (us_cnt_q > TimeoutCnt);

   assign bus.sensor_data = data_q;
   assign bus.error       = error_q;
   assign bus.dadosOK     = ok_q;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; an edge always takes priority over a timeout in the same cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (start) state_d = StStartLow;
         StStartLow: begin
            if (!bus.enable)               state_d = StIdle;
            else if (us_cnt_q == StartCnt) state_d = StWaitResp;
         end
         StWaitResp: begin
            if (!bus.enable)  state_d = StIdle;
            else if (fall)    state_d = StRespLow;
            else if (timeout) state_d = StFail;
         end
         StRespLow: begin
            if (!bus.enable)  state_d = StIdle;
            else if (rise)    state_d = StRespHigh;
            else if (timeout) state_d = StFail;
         end
         StRespHigh: begin
            if (!bus.enable)  state_d = StIdle;
            else if (fall)    state_d = StBitLow;
            else if (timeout) state_d = StFail;
         end
         StBitLow: begin
            if (!bus.enable)  state_d = StIdle;
            else if (rise)    state_d = StBitHigh;
            else if (timeout) state_d = StFail;
         end
         StBitHigh: begin
            if (!bus.enable)  state_d = StIdle;
            else if (fall)    state_d = (bit_idx_q == 6'd39) ? StDone : StBitLow;
            else if (timeout) state_d = StFail;
         end
         StDone:     state_d = StHold;
         StFail:     state_d = StHold;
         StHold:     if (!bus.enable) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Output / datapath next-state logic
   always_comb begin
      presc_d     = tick ? '0 : presc_q + 1'b1;
      us_cnt_d    = us_cnt_q;
      guard_d     = guard_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      error_d     = error_q;
      ok_d        = ok_q;
      // Line is held low exactly while the start pulse state is (or becomes) current
      drive_low_d = (state_d == StStartLow);

      if (state_d != state_q) begin
         us_cnt_d = '0;
      end else if (tick) begin
         us_cnt_d = us_cnt_q + 1'b1;
      end

      if (start) begin
         guard_d = '0;
      end else if (tick && (guard_q != MinCnt)) begin
         guard_d = guard_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               error_d = 1'b0;
               ok_d    = 1'b0;
            end
         end
         StRespHigh: if (state_d == StBitLow) bit_idx_d = '0;
         StBitHigh: begin
            // Bit value is the length of the high phase just ended, MSB first
            if ((state_d == StBitLow) || (state_d == StDone)) begin
               shift_d   = {shift_q[38:0], (us_cnt_q > ThreshCnt)};
               bit_idx_d = bit_idx_q + 1'b1;
            end
         end
         StDone: begin
            data_d = shift_q;
            ok_d   = 1'b1;
         end
         StFail: error_d = 1'b1;
         StHold: if (!bus.enable) ok_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_q     <= '0;
         us_cnt_q    <= '0;
         guard_q     <= MinCnt;  // first request after reset is not delayed
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         drive_low_q <= 1'b0;
         error_q     <= 1'b0;
         ok_q        <= 1'b0;
         // Idle line reads high; preset avoids a false edge after reset
         meta_q      <= 1'b1;
         sync_q      <= 1'b1;
         prev_q      <= 1'b1;
      end else begin
         presc_q     <= presc_d;
         us_cnt_q    <= us_cnt_d;
         guard_q     <= guard_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         drive_low_q <= drive_low_d;
         error_q     <= error_d;
         ok_q        <= ok_d;
         meta_q      <= transmission_line;
         sync_q      <= meta_q;
         prev_q      <= sync_q;
      end
   end

endmodule

// File: tb/tb_dht11_driver.sv
// tb_dht11_driver: drives dht11_driver against a behavioural DHT11 sensor model with
// randomized frames and phase timings. A transaction-level model holds the expected
// sensor_data/error/dadosOK and is compared against the DUT on every negative clock edge.
module tb_dht11_driver;

   localparam int unsigned StartLow  = 200;
   localparam int unsigned MinInt    = 2000;
   localparam int unsigned TimeoutUs = 100;

   logic        clock    = 1'b0;
   logic        reset_n  = 1'b0;
   logic        sens_low = 1'b0;
   wire         line;
   int          checks   = 0;
   int          errors   = 0;
   int unsigned cyc_cnt  = 0;
   logic [39:0] exp_data = '0;
   logic        exp_err  = 1'b0;
   logic        exp_ok   = 1'b0;
   logic        chk_en   = 1'b0;

   dht11_driver_if bus ();

   pullup (line);
   assign line = sens_low ? 1'b0 : 1'bz;

   dht11_driver #(
      .CLK_CYCLES_PER_US(1),
      .START_LOW_US     (StartLow),
      .TIMEOUT_US       (TimeoutUs),
      .BIT_THRESHOLD_US (48),
      .MIN_INTERVAL_US  (MinInt)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .transmission_line(line),
      .bus              (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Model comparison on every cycle once out of the initial reset
   always @(negedge clock) begin
      if (chk_en) begin
         check("cmp_outputs", {22'b0, bus.sensor_data, bus.error, bus.dadosOK},
               {22'b0, exp_data, exp_err, exp_ok});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Cycles until the line reads lvl, -1 if not within max
   task automatic wait_line(input logic lvl, input int max, output int n);
      n = 0;
      while (line !== lvl && n < max) begin
         cyc(1);
         n++;
      end
      if (line !== lvl) n = -1;
   endtask

   task automatic wait_flag(input bit want_ok, input int max, output int n);
      n = 0;
      while (((want_ok ? bus.dadosOK : bus.error) !== 1'b1) && n < max) begin
         cyc(1);
         n++;
      end
      if ((want_ok ? bus.dadosOK : bus.error) !== 1'b1) n = -1;
   endtask

   // Request a read and wait for the host start pulse; a start clears both flags
   task automatic begin_read(input int max, output int n, output int t);
      bus.enable = 1'b1;
      wait_line(1'b0, max, n);
      check_range("start_pulse_seen", n, 0, max);
      t = int'(cyc_cnt);
      if (n >= 0) begin
         exp_err = 1'b0;
         exp_ok  = 1'b0;
      end
   endtask

   task automatic host_pulse();
      int n;
      wait_line(1'b1, StartLow + 20, n);
      check_range("start_low_len", n, StartLow, StartLow + 1);
   endtask

   task automatic drop_enable();
      bus.enable = 1'b0;
      cyc(1);
      exp_ok = 1'b0;
   endtask

   // Sensor reply: response low/high, then 40 bits MSB first. stretch_bit holds that bit's
   // high phase for 150us; abort_bit returns 10us into that bit's high phase.
   task automatic sensor_frame(input logic [39:0] frame, input int stretch_bit,
                               input int abort_bit);
      int n;
      cyc($urandom_range(20, 40));
      sens_low = 1'b1;
      cyc($urandom_range(75, 85));
      sens_low = 1'b0;
      cyc($urandom_range(75, 85));
      for (int b = 0; b < 40; b++) begin
         sens_low = 1'b1;
         cyc($urandom_range(45, 55));
         sens_low = 1'b0;
         if (b == abort_bit) begin
            cyc(10);
            return;
         end
         if (b == stretch_bit) begin
            wait_flag(1'b0, 200, n);
            check_range("stretch_timeout", n, TimeoutUs + 1, TimeoutUs + 8);
            if (n >= 0) begin
               exp_err = 1'b1;
               if (n < 150) cyc(150 - n);
            end
            return;
         end
         cyc(frame[39-b] ? $urandom_range(65, 75) : $urandom_range(22, 30));
      end
      sens_low = 1'b1;
      wait_flag(1'b1, 10, n);
      // 2 synchronizer stages + DONE + output register
      check_range("done_latency", n, 4, 4);
      if (n >= 0) begin
         exp_data = frame;
         exp_ok   = 1'b1;
         cyc(50 - n);
      end else begin
         cyc(50);
      end
      sens_low = 1'b0;
      cyc(1);
   endtask

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, t_a, t_b;
      logic [39:0] fr;
      bus.enable = 1'b0;
      reset_n    = 1'b0;
      cyc(3);
      check("reset_line", {63'b0, line}, 64'd1);
      check("reset_outputs", {22'b0, bus.sensor_data, bus.error, bus.dadosOK}, 64'd0);
      chk_en  = 1'b1;
      reset_n = 1'b1;

      // Nominal read, immediate start after reset
      begin_read(5, n, t_a);
      check_range("first_start_no_guard", n, 0, 3);
      host_pulse();
      sensor_frame(40'h3700190050, -1, -1);
      check("nominal_data", {24'b0, bus.sensor_data}, 64'h3700190050);
      check("nominal_ok", {63'b0, bus.dadosOK}, 64'd1);
      cyc(20);
      drop_enable();
      check("drop_ok", {63'b0, bus.dadosOK}, 64'd0);
      check("drop_keeps_data", {24'b0, bus.sensor_data}, 64'h3700190050);

      // No sensor response
      cyc(5);
      begin_read(2100, n, t_a);
      host_pulse();
      wait_flag(1'b0, 200, n);
      check_range("noresp_timeout", n, TimeoutUs + 1, TimeoutUs + 6);
      if (n >= 0) exp_err = 1'b1;
      check("noresp_ok", {63'b0, bus.dadosOK}, 64'd0);
      check("noresp_data_kept", {24'b0, bus.sensor_data}, 64'h3700190050);
      drop_enable();

      // Immediate re-request is held off by the start-to-start guard; bit 12 stretched
      begin_read(2100, n, t_b);
      check_range("guard_interval", t_b - t_a, MinInt, MinInt + 1);
      host_pulse();
      fr[39:8] = $urandom();
      fr[7:0]  = 8'($urandom_range(0, 255));
      sensor_frame(fr, 12, -1);
      cyc(2);
      check("stretch_line_released", {63'b0, line}, 64'd1);
      check("stretch_error", {63'b0, bus.error}, 64'd1);
      check("stretch_data_kept", {24'b0, bus.sensor_data}, 64'h3700190050);
      drop_enable();

      // Abort during bit 20, then abort during the start pulse
      begin_read(2100, n, t_a);
      host_pulse();
      sensor_frame(fr, -1, 20);
      bus.enable = 1'b0;
      cyc(1);
      check("abort_line", {63'b0, line}, 64'd1);
      check("abort_flags", {62'b0, bus.error, bus.dadosOK}, 64'd0);
      cyc(400);
      begin_read(5, n, t_a);
      check_range("restart_after_abort", n, 0, 3);
      cyc(50);
      bus.enable = 1'b0;
      cyc(1);
      check("startlow_abort_line", {63'b0, line}, 64'd1);

      // Randomized reads
      for (int r = 0; r < 3; r++) begin
         fr[39:8] = $urandom();
         fr[7:0]  = 8'($urandom_range(0, 255));
         cyc($urandom_range(1, 30));
         begin_read(2100, n, t_a);
         host_pulse();
         sensor_frame(fr, -1, -1);
         cyc($urandom_range(1, 40));
         drop_enable();
      end

      // Asynchronous reset in the middle of the start pulse
      begin_read(2100, n, t_a);
      cyc(50);
      exp_data = '0;
      exp_err  = 1'b0;
      exp_ok   = 1'b0;
      reset_n  = 1'b0;
      #1;
      check("async_reset_line", {63'b0, line}, 64'd1);
      check("async_reset_outputs", {22'b0, bus.sensor_data, bus.error, bus.dadosOK}, 64'd0);
      cyc(3);
      reset_n = 1'b1;
      begin_read(5, n, t_a);
      check_range("post_reset_no_guard", n, 0, 3);
      host_pulse();
      fr[39:8] = $urandom();
      fr[7:0]  = 8'($urandom_range(0, 255));
      sensor_frame(fr, -1, -1);
      cyc(5);
      drop_enable();
      cyc(5);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
